mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
- Parametrised iterative multiply/divide unit that replaces the single-cycle MUL path feeding the Z register pair.
- Performs signed or unsigned WIDTH x WIDTH multiply (radix-2 Booth) and signed or unsigned divide (restoring), one bit per clock.
- Returns the 2*WIDTH result as hi/lo words that the datapath writes into HI/LO.
- Uses a start/busy/done handshake so the control unit can stall the T-state sequence until done.

Parameters:
- WIDTH, 32, operand width in bits; must be even and at least 4.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  reset, synchronous and active-low; the unit resets when clear=0 is sampled on a rising clock edge.
- start  in  1  request; sampled only in IDLE.
- op_div  in  1  0 = multiply, 1 = divide; sampled with start.
- op_signed  in  1  1 = two's-complement operands; sampled with start.
- a  in  WIDTH  multiplicand or dividend (the Y-side operand); sampled with start.
- b  in  WIDTH  multiplier or divisor (the bus-side operand); sampled with start.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse; hi/lo/div_by_zero are valid during the pulse.
- hi  out  WIDTH  multiply: upper product; divide: remainder.
- lo  out  WIDTH  multiply: lower product; divide: quotient.
- div_by_zero  out  1  set with done when a divide had b==0; cleared on the next accept.

Behaviour:
- Reset (clear=0 at an edge): state IDLE; busy=0, done=0, hi=0, lo=0, div_by_zero=0; counter=0.
- Reset has priority over every other input, including mid-operation. An operation in progress is aborted and produces no done.
- States: IDLE, LOAD, ITER, FIXUP, DONE.
- IDLE: an edge with start=1 latches a, b, op_div and op_signed, and moves to LOAD. start=0 stays in IDLE.
- LOAD: busy=1.
  - Divide: records operand signs and forms magnitudes when op_signed=1.
  - Divide with b==0: goes directly to DONE with lo={WIDTH{1}}, hi=a (original value), div_by_zero=1.
  - Otherwise: counter=WIDTH, go to ITER.
- ITER:
  - Multiply: one Booth step per cycle on a {acc, multiplier, q-1} register. The accumulator is WIDTH+1 bits, so unsigned operands with MSB=1 are handled by zero-extension.
  - Divide: one restoring shift/subtract step per cycle.
  - The counter decrements each cycle; go to FIXUP when it reaches 1.
- FIXUP:
  - Signed divide: negates the quotient if the operand signs differ, and negates the remainder if the dividend is negative. The remainder takes the sign of the dividend (truncating division).
  - Multiply: no-op cycle.
  - Go to DONE.
- DONE: done=1 for exactly one cycle, busy=0; hi/lo are updated; return to IDLE.
- Latency: a start edge at cycle n gives done high in cycle n+WIDTH+3. A divide by zero gives done high in cycle n+2.
- hi, lo and div_by_zero hold their values until the next accepted start or reset.
- start while busy: ignored, not queued.
- start in the DONE cycle: ignored; it is accepted from IDLE in the next cycle.
- Signed overflow (a = -2^(WIDTH-1), b = -1, divide): lo = 0x80..0, hi = 0, no flag.
- Multiply results are exact in 2*WIDTH bits; no overflow flag.

Optional Feature:
- Macro: MUL_DIV_UNIT_DIV_EN.
- Defined: full divide support as above.
- Undefined:
  - Divide hardware and the FIXUP negation logic are removed.
  - A request with op_div=1 goes IDLE -> LOAD -> DONE: done in cycle n+2, hi=0, lo=0, div_by_zero=1 (reused as the illegal-op flag).
  - Multiply timing is unchanged.

Test Plan (WIDTH=32):
- Unsigned multiply, a=0x12, b=0x14 -> done at start+35; hi=0x00000000, lo=0x00000168; busy high for 34 cycles.
- Signed multiply, a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Unsigned multiply, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed divide, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Unsigned divide, a=100, b=7 -> lo=14, hi=2.
- Divide by zero, a=0x1234, b=0 -> done at start+2; lo=0xFFFFFFFF, hi=0x00001234, div_by_zero=1. Next valid start clears div_by_zero. Without MUL_DIV_UNIT_DIV_EN, any op_div=1 request -> hi=lo=0, div_by_zero=1.
- Signed overflow divide, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0. Pulse start again while busy -> no extra done; result unchanged.
- Assert clear=0 for one edge at start+10 of a multiply -> next cycle busy=0, done=0, hi=lo=0; no done ever pulses for that operation; a fresh start then completes normally.

Source files
------------

// File: rtl/mul_div_unit_if.sv
// ---------------------------------------------------------------------------
// mul_div_unit_if : request/response bundle between the control unit and
//                   the iterative multiply/divide unit.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op_div;
    logic             op_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op_div, op_signed, a, b,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op_div, op_signed, a, b,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit : iterative radix-2 Booth multiply / restoring divide, one bit
//                per clock. Divide support built only with MUL_DIV_UNIT_DIV_EN.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic           clock,
    input  logic           clear,
    mul_div_unit_if.slave  bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] ITER  = 3'd2;
    localparam logic [2:0] FIXUP = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] mq;
    logic [WIDTH:0]   acc;
    logic             q_1;
    logic             op_div_r;
    logic             op_signed_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             dbz_r;

    logic [WIDTH:0]   mcand;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH-1:0] mul_hi;

    assign mcand = {op_signed_r & a_reg[WIDTH-1], a_reg};

    always_comb begin
        booth_sum = acc;
        case ({mq[0], q_1})
            2'b01:   booth_sum = acc + mcand;
            2'b10:   booth_sum = acc - mcand;
            default: booth_sum = acc;
        endcase
    end

    // Booth treats the multiplier as signed; an unsigned multiplier with its
    // MSB set therefore lacks a*2^WIDTH, restored here in the fixup cycle.
    assign mul_hi = acc[WIDTH-1:0]
                  + ((!op_signed_r && b_reg[WIDTH-1]) ? a_reg : '0);

`ifdef MUL_DIV_UNIT_DIV_EN
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_sub;
    logic             div_ge;

    assign div_shift = {acc[WIDTH-1:0], mq[WIDTH-1]};
    assign div_sub   = div_shift - {1'b0, b_reg};
    assign div_ge    = (div_shift >= {1'b0, b_reg});
`endif

    always_ff @(posedge clock) begin
        if (!clear) begin
            state       <= IDLE;
            count       <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            mq          <= '0;
            acc         <= '0;
            q_1         <= 1'b0;
            op_div_r    <= 1'b0;
            op_signed_r <= 1'b0;
            hi_r        <= '0;
            lo_r        <= '0;
            dbz_r       <= 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg       <= bus.a;
                        b_reg       <= bus.b;
                        op_div_r    <= bus.op_div;
                        op_signed_r <= bus.op_signed;
                        dbz_r       <= 1'b0;
                        state       <= LOAD;
                    end
                end

                LOAD: begin
`ifdef MUL_DIV_UNIT_DIV_EN
                    if (op_div_r) begin
                        if (b_reg == '0) begin
                            hi_r  <= a_reg;
                            lo_r  <= '1;
                            dbz_r <= 1'b1;
                            state <= DONE;
                        end else begin
                            neg_q <= op_signed_r & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
                            neg_r <= op_signed_r & a_reg[WIDTH-1];
                            mq    <= (op_signed_r && a_reg[WIDTH-1]) ? -a_reg : a_reg;
                            b_reg <= (op_signed_r && b_reg[WIDTH-1]) ? -b_reg : b_reg;
                            acc   <= '0;
                            count <= CNT_W'(WIDTH);
                            state <= ITER;
                        end
                    end else begin
`else
                    if (op_div_r) begin
                        hi_r  <= '0;
                        lo_r  <= '0;
                        dbz_r <= 1'b1;
                        state <= DONE;
                    end else begin
`endif
                        acc   <= '0;
                        mq    <= b_reg;
                        q_1   <= 1'b0;
                        count <= CNT_W'(WIDTH);
                        state <= ITER;
                    end
                end

                ITER: begin
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state <= FIXUP;
                    end
`ifdef MUL_DIV_UNIT_DIV_EN
                    if (op_div_r) begin
                        if (div_ge) begin
                            acc <= div_sub;
                            mq  <= {mq[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= div_shift;
                            mq  <= {mq[WIDTH-2:0], 1'b0};
                        end
                    end else begin
`else
                    begin
`endif
                        acc <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                        mq  <= {booth_sum[0], mq[WIDTH-1:1]};
                        q_1 <= mq[0];
                    end
                end

                FIXUP: begin
`ifdef MUL_DIV_UNIT_DIV_EN
                    if (op_div_r) begin
                        lo_r <= neg_q ? -mq : mq;
                        hi_r <= neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                    end else begin
`else
                    begin
`endif
                        hi_r <= mul_hi;
                        lo_r <= mq;
                    end
                    state <= DONE;
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = (state == LOAD) || (state == ITER) || (state == FIXUP);
    assign bus.done        = (state == DONE);
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;
    assign bus.div_by_zero = dbz_r;

endmodule

`default_nettype wire
